// File: rtl/dft_pkg.sv
// ----------------------------------------------------------------------------
// dft_pkg
// Types and sizes shared by the DFT datapath blocks.
//   N_POINTS  : complex points per frame
//   W_DBL     : bits per real or imaginary part (IEEE-754 double bit pattern)
//   complex_t : [1:0] of W_DBL, index 0 = real part, index 1 = imaginary part
//   frame_t   : [N_POINTS-1:0] of complex_t, one full parallel frame
// ----------------------------------------------------------------------------
package dft_pkg;

    localparam int N_POINTS = 16;
    localparam int W_DBL    = 64;

    typedef logic [1:0][W_DBL-1:0]    complex_t;
    typedef complex_t [N_POINTS-1:0]  frame_t;

endpackage : dft_pkg

// File: rtl/dft_frame_streamer.sv
// ----------------------------------------------------------------------------
// dft_frame_streamer
// Captures one parallel complex frame and replays it as a stream of N
// elements, one element per output handshake, in index order 0..N-1.
// Data bits pass through untouched.
//
// Ports
//   clk       : clock, all state updates on the rising edge
//   rst_n     : synchronous active-low reset (beats flush and handshakes)
//   in_frame  : parallel frame, [k][0] real, [k][1] imaginary
//   in_valid  : in_frame is valid
//   in_ready  : a frame is accepted this cycle if in_valid is also high
//   flush     : synchronous abort of the current frame
//   out_valid : out_re/out_im/out_idx/out_last are valid
//   out_ready : downstream accepts the current element
//   out_re    : real part bit pattern of element out_idx
//   out_im    : imaginary part bit pattern of element out_idx
//   out_idx   : element index k
//   out_last  : out_idx is N-1 while out_valid is high
//   busy      : block is in STREAM (also the observable FSM state)
//
// Handshake semantics: a transfer happens on a rising edge where valid and
// ready are both high; valid never depends on ready, and once out_valid is
// raised the element (data, index, last) stays stable until it transfers or
// the frame is aborted by flush or reset. in_ready is combinational from
// out_ready so a new frame can be taken on the last beat without a bubble.
// ----------------------------------------------------------------------------
module dft_frame_streamer
    import dft_pkg::*;
#(
    parameter int N = N_POINTS,
    parameter int W = W_DBL
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  frame_t                in_frame,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  flush,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [W-1:0]          out_re,
    output logic [W-1:0]          out_im,
    output logic [$clog2(N)-1:0]  out_idx,
    output logic                  out_last,
    output logic                  busy
);

    localparam int IW = $clog2(N);

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_STREAM = 1'b1
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    frame_t          r_buf;
    logic [IW-1:0]   r_idx;
    logic [IW-1:0]   w_idx_inc;
    logic [W-1:0]    r_re;
    logic [W-1:0]    r_im;
    logic            w_hs;
    logic            w_at_last;
    logic            w_accept;

    assign w_at_last = (r_idx == IW'(N - 1));
    assign w_idx_inc = r_idx + IW'(1);
    assign w_hs      = out_valid && out_ready;
    // flush blocks acceptance even in IDLE, where in_ready alone is high
    assign w_accept  = in_valid && in_ready && !flush;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = S_STREAM;
                end
            end
            S_STREAM: begin
                if (flush) begin
                    w_state_nxt = S_IDLE;
                end else if (w_accept) begin
                    // back-to-back frame taken on the last beat
                    w_state_nxt = S_STREAM;
                end else if (w_hs && w_at_last) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        out_valid = (r_state == S_STREAM);
        busy      = (r_state == S_STREAM);
        out_last  = (r_state == S_STREAM) && w_at_last;
        in_ready  = (r_state == S_IDLE) ||
                    ((r_state == S_STREAM) && out_ready && w_at_last && !flush);
    end

    // ------------------------------------------------------------------
    // Frame buffer: never reset, only written on an accepted frame
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst_n && w_accept) begin
            r_buf <= in_frame;
        end
    end

    // ------------------------------------------------------------------
    // Index counter and output element registers. The element registers
    // are loaded from the incoming frame on accept (the buffer is not yet
    // written) and from the buffer at idx+1 on each advance, so the outputs
    // are registered and stay put while stalled or idle.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_idx <= '0;
            r_re  <= '0;
            r_im  <= '0;
        end else if (flush) begin
            r_idx <= '0;
        end else if (w_accept) begin
            r_idx <= '0;
            r_re  <= in_frame[0][0];
            r_im  <= in_frame[0][1];
        end else if (w_hs && !w_at_last) begin
            r_idx <= w_idx_inc;
            r_re  <= r_buf[w_idx_inc][0];
            r_im  <= r_buf[w_idx_inc][1];
        end
    end

    assign out_re  = r_re;
    assign out_im  = r_im;
    assign out_idx = r_idx;

endmodule : dft_frame_streamer

// File: tb/tb_dft_frame_streamer.sv
// ----------------------------------------------------------------------------
// tb_dft_frame_streamer
// Table of frame patterns (data formula, out_ready pattern, expected beat
// count) plus hand-written sequences for back-to-back, flush, reset and the
// flush-on-last-beat corner. Expected elements go into exp_q when a frame is
// seen to be accepted and are popped on each output handshake.
// ----------------------------------------------------------------------------
module tb_dft_frame_streamer;
    import dft_pkg::*;

    localparam int N  = 16;
    localparam int W  = 64;
    localparam int IW = 4;
    localparam int EW = IW + 2 * W;

    // ---------------- clock / reset / DUT ----------------
    logic           clk = 1'b0;
    logic           rst_n;
    frame_t         in_frame;
    logic           in_valid;
    logic           in_ready;
    logic           flush;
    logic           out_valid;
    logic           out_ready;
    logic [W-1:0]   out_re;
    logic [W-1:0]   out_im;
    logic [IW-1:0]  out_idx;
    logic           out_last;
    logic           busy;

    always #5 clk = ~clk;

    dft_frame_streamer #(.N(N), .W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_frame  (in_frame),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_re    (out_re),
        .out_im    (out_im),
        .out_idx   (out_idx),
        .out_last  (out_last),
        .busy      (busy)
    );

    // ---------------- bookkeeping ----------------
    int             tests    = 0;
    int             fails    = 0;
    int             beat_cnt = 0;
    int             cyc      = 0;
    logic [3:0]     rdy_pat  = 4'b1111;
    logic [EW-1:0]  exp_q[$];

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_true(input string name, input bit ok);
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL %s: condition false (t=%0t)", name, $time);
        end
    endtask

    // ---------------- out_ready driver ----------------
    initial begin
        out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            out_ready = rdy_pat[2'(cyc % 4)];
        end
    end

    // ---------------- scoreboard / monitor ----------------
    initial begin : monitor
        logic [EW-1:0]  e;
        logic           stall_prev;
        logic [W-1:0]   p_re;
        logic [W-1:0]   p_im;
        logic [IW-1:0]  p_idx;
        stall_prev = 1'b0;
        p_re  = '0;
        p_im  = '0;
        p_idx = '0;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && flush === 1'b0) begin
                if (stall_prev) begin
                    check("stall_valid", W'(out_valid), W'(1));
                    check("stall_re",    out_re,        p_re);
                    check("stall_im",    out_im,        p_im);
                    check("stall_idx",   W'(out_idx),   W'(p_idx));
                end
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL unexpected_beat: idx %0d with empty queue (t=%0t)", out_idx, $time);
                    end else begin
                        e = exp_q.pop_front();
                        beat_cnt++;
                        check("beat_idx",  W'(out_idx),  W'(e[EW-1 -: IW]));
                        check("beat_re",   out_re,       e[2*W-1 -: W]);
                        check("beat_im",   out_im,       e[W-1:0]);
                        check("beat_last", W'(out_last), W'(e[EW-1 -: IW] == IW'(N - 1)));
                    end
                end
                stall_prev = out_valid && !out_ready;
                p_re  = out_re;
                p_im  = out_im;
                p_idx = out_idx;
            end else begin
                stall_prev = 1'b0;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    function automatic frame_t build(input int rb, input int rs, input int ib, input int isx, input bit rnd);
        frame_t f;
        for (int k = 0; k < N; k++) begin
            if (rnd) begin
                f[k][0] = {$urandom, $urandom};
                f[k][1] = {$urandom, $urandom};
            end else begin
                f[k][0] = $realtobits(real'(rb + rs * k));
                f[k][1] = $realtobits(real'(ib + isx * k));
            end
        end
        return f;
    endfunction

    // Holds in_valid until the frame is accepted, queues its elements, then
    // checks that element 0 is presented exactly one cycle after accept.
    task automatic send_frame(input frame_t f);
        bit ok;
        ok       = 1'b0;
        in_frame = f;
        in_valid = 1'b1;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            if (in_ready && !flush) begin
                ok = 1'b1;
                for (int k = 0; k < N; k++) begin
                    exp_q.push_back({IW'(k), f[k][0], f[k][1]});
                end
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        check_true("accept_timeout", ok);
        if (ok) begin
            @(negedge clk);
            check("first_valid", W'(out_valid), W'(1));
            check("first_idx",   W'(out_idx),   W'(0));
        end
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 400 && !ok; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !busy) ok = 1'b1;
        end
        check_true("drain_timeout", ok);
        check("idle_valid", W'(out_valid), W'(0));
        check("idle_ready", W'(in_ready),  W'(1));
    endtask

    // Returns at posedge+1 of the cycle in which element tgt is presented.
    task automatic wait_idx(input int tgt);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(posedge clk);
            #1;
            if (out_valid && out_idx == IW'(tgt)) ok = 1'b1;
        end
        check_true("wait_idx_timeout", ok);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        int         re_b;
        int         re_s;
        int         im_b;
        int         im_s;
        bit         rnd;
        logic [3:0] rdy;
        int         beats;
    } vec_t;

    vec_t vecs[4];

    // ---------------- main sequence ----------------
    initial begin
        frame_t fa;
        frame_t fb;

        vecs[0] = '{re_b: 0, re_s: 2,  im_b: 0,  im_s: 0, rnd: 1'b0, rdy: 4'b1111, beats: 16};
        vecs[1] = '{re_b: 0, re_s: 2,  im_b: 0,  im_s: 0, rnd: 1'b0, rdy: 4'b1001, beats: 16};
        vecs[2] = '{re_b: 7, re_s: -3, im_b: -5, im_s: 4, rnd: 1'b0, rdy: 4'b0101, beats: 16};
        vecs[3] = '{re_b: 0, re_s: 0,  im_b: 0,  im_s: 0, rnd: 1'b1, rdy: 4'b0111, beats: 16};

        rst_n    = 1'b0;
        in_valid = 1'b0;
        flush    = 1'b0;
        in_frame = '0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // reset state
        @(negedge clk);
        check("rst_valid", W'(out_valid), W'(0));
        check("rst_busy",  W'(busy),      W'(0));
        check("rst_last",  W'(out_last),  W'(0));
        check("rst_ready", W'(in_ready),  W'(1));
        check("rst_re",    out_re,        W'(0));
        check("rst_im",    out_im,        W'(0));
        check("rst_idx",   W'(out_idx),   W'(0));
        @(posedge clk);
        #1;

        // table-driven frames
        for (int v = 0; v < 4; v++) begin
            rdy_pat  = vecs[v].rdy;
            beat_cnt = 0;
            fa = build(vecs[v].re_b, vecs[v].re_s, vecs[v].im_b, vecs[v].im_s, vecs[v].rnd);
            send_frame(fa);
            wait_idle();
            check("vec_beats", W'(beat_cnt), W'(vecs[v].beats));
            @(posedge clk);
            #1;
        end

        // back-to-back: B waits for A's last beat, B idx 0 follows A idx 15
        rdy_pat  = 4'b1111;
        beat_cnt = 0;
        fa = build(0, 2, 0, 0, 1'b0);
        fb = build(1, 2, 0, 0, 1'b0);
        send_frame(fa);
        send_frame(fb);
        wait_idle();
        check("b2b_beats", W'(beat_cnt), W'(32));
        @(posedge clk);
        #1;

        // flush at idx 5
        fa = build(100, 1, 3, 0, 1'b0);
        send_frame(fa);
        wait_idx(5);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check("flush_valid", W'(out_valid), W'(0));
        check("flush_ready", W'(in_ready),  W'(1));
        check("flush_busy",  W'(busy),      W'(0));
        check("flush_idx",   W'(out_idx),   W'(0));
        @(posedge clk);
        #1;
        beat_cnt = 0;
        fb = build(-8, 5, 1, 1, 1'b0);
        send_frame(fb);
        wait_idle();
        check("flush_next_beats", W'(beat_cnt), W'(16));
        @(posedge clk);
        #1;

        // reset at idx 9 for one cycle
        fa = build(3, 3, 9, -1, 1'b0);
        send_frame(fa);
        wait_idx(9);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        exp_q.delete();
        @(negedge clk);
        check("mrst_valid", W'(out_valid), W'(0));
        check("mrst_busy",  W'(busy),      W'(0));
        check("mrst_re",    out_re,        W'(0));
        check("mrst_im",    out_im,        W'(0));
        check("mrst_ready", W'(in_ready),  W'(1));
        @(posedge clk);
        #1;
        beat_cnt = 0;
        fb = build(0, 0, 0, 0, 1'b1);
        send_frame(fb);
        wait_idle();
        check("mrst_next_beats", W'(beat_cnt), W'(16));
        @(posedge clk);
        #1;

        // flush together with last-beat handshake and a waiting frame
        fa = build(50, -1, 0, 2, 1'b0);
        fb = build(1, 1, 1, 1, 1'b0);
        send_frame(fa);
        wait_idx(15);
        flush    = 1'b1;
        in_frame = fb;
        in_valid = 1'b1;
        @(negedge clk);
        check("fl_last_in_ready", W'(in_ready), W'(0));
        @(posedge clk);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check("fl_last_valid", W'(out_valid), W'(0));
        check("fl_last_busy",  W'(busy),      W'(0));
        @(negedge clk);
        check("fl_last_still_idle", W'(busy), W'(0));
        check("fl_last_ready",      W'(in_ready), W'(1));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // ---------------- watchdog ----------------
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d tests run", tests);
        $fatal(1, "watchdog expired");
    end

endmodule : tb_dft_frame_streamer
